seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
Parametrised serial pattern detector, the successor to the fixed 3-ones detector. Pattern value and length are runtime-programmable up to PAT_W bits, with selectable overlapping or non-overlapping detection and a saturating match counter. Sits on a 1-bit serial stream with a per-bit valid qualifier and feeds match pulses to control/status logic.

Parameters:
PAT_W, 8, maximum pattern length in bits (>=2)
CNT_W, 8, match counter width
LEN_W, $clog2(PAT_W+1), width of length field (derived, do not override)

Ports:
clk  in  1  clock, all logic on rising edge
rstn  in  1  asynchronous active-low reset
in_valid  in  1  qualifies in; bit consumed only when high in RUN
in  in  1  serial data bit
start  in  1  single-cycle pulse: latch config, clear history/counter, arm
stop  in  1  single-cycle pulse: disarm, return to IDLE
pattern  in  PAT_W  pattern; pattern[pat_len-1] is the first-received bit, pattern[0] the last
pat_len  in  LEN_W  pattern length; legal range 1..PAT_W
overlap  in  1  1 = overlapping detection, 0 = non-overlapping
out  out  1  registered match pulse, one cycle
busy  out  1  high in RUN
cfg_err  out  1  one-cycle pulse: start seen with illegal pat_len
match_cnt  out  CNT_W  saturating match count (see Optional Feature)

Behaviour:
- Reset (rstn low, async): state=IDLE, history=0, fill=0, out=0, busy=0, cfg_err=0, match_cnt=0, config registers=0.
- FSM states: IDLE, RUN.
- IDLE: in/in_valid ignored; out=0. On start with pat_len in 1..PAT_W: latch pattern/pat_len/overlap, clear history, fill and match_cnt, go to RUN. On start with pat_len=0 or >PAT_W: cfg_err=1 next cycle, stay IDLE, config unchanged.
- RUN: pattern/pat_len/overlap inputs ignored (latched copies used). On in_valid: history <= {history[PAT_W-2:0], in}; fill <= min(fill+1, len).
- Match condition, evaluated on the accepted bit: (fill+1 >= len) and next history[len-1:0] == pattern_q[len-1:0] (upper bits masked).
- Match -> out=1 on the cycle after the completing bit is sampled (latency 1), and match_cnt increments.
- overlap=1: history and fill retained after a match. overlap=0: fill cleared to 0 on the match; the next match needs len fresh bits.
- in_valid low: no shift, no match, out=0.
- stop in RUN: go to IDLE next cycle, out=0, match_cnt held.
- start in RUN: re-latch config exactly as from IDLE (re-arm). The bit on the same cycle is discarded. If start and stop assert together, start wins.
- start with illegal length while in RUN: cfg_err pulse, state goes to IDLE.
- match_cnt saturates at 2^CNT_W-1 and is cleared only by reset or a legal start.

Optional Feature:
Macro SEQ_DETECTOR_CNT_EN. Defined: match_cnt is implemented as specified. Undefined: counter logic omitted; match_cnt is tied to 0. Port list is identical in both builds.

Decomposition:
- Package seq_detector_pkg: state enum (IDLE, RUN) and a len_w(PAT_W) constant function.
- Sub-module: seq_detector_cnt, the saturating CNT_W counter with clear/inc, instantiated under SEQ_DETECTOR_CNT_EN.
- History shift, mask-compare and FSM stay in the top module.

Test Plan:
- pattern=4'b1101, pat_len=4, overlap=1, stream 1,1,0,1,1,0,1 all valid -> out pulses after bits 4 and 7; match_cnt=2.
- Same stream with overlap=0 -> single pulse after bit 4; match_cnt=1.
- pattern=3'b111, len=3, stream of five 1s -> overlap=1 gives 3 pulses; overlap=0 gives 1 pulse.
- start with pat_len=0 and with pat_len=PAT_W+1 -> cfg_err pulse each time, busy stays 0, no out.
- 1101 stream with in_valid gaps of 2 cycles between bits -> same match points as contiguous; out never asserts on invalid cycles.
- CNT_W=2, ten overlapping "11" matches -> match_cnt holds at 3. rstn low mid-stream -> all outputs 0 immediately; after release, detection needs a new start.

Source files
------------

// File: rtl/seq_detector_pkg.sv
// Shared types and helpers for the parametrised serial pattern detector.
package seq_detector_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Width needed to hold a length value in the range 0..pat_w.
    function automatic int len_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seq_detector_cnt.sv
// Saturating match counter: a synchronous clear takes priority over an increment.
module seq_detector_cnt
    import seq_detector_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_r;

    // Count register: it holds at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (inc && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with overlap control.
// Define SEQ_DETECTOR_CNT_EN to build the saturating match counter; otherwise match_cnt is tied to 0.
module seq_detector_param
    import seq_detector_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8,
    parameter int LEN_W = len_w(PAT_W)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    input  logic             in,
    input  logic             start,
    input  logic             stop,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] pat_len,
    input  logic             overlap,
    output logic             out,
    output logic             busy,
    output logic             cfg_err,
    output logic [CNT_W-1:0] match_cnt
);

    state_t           state_r, state_n;
    logic [PAT_W-2:0] history_r;
    logic [PAT_W-1:0] pattern_r, hist_next_s, mask_s;
    logic [LEN_W-1:0] len_r, fill_r, fill_n;
    logic [LEN_W:0]   fill_inc_s;
    logic             overlap_r, out_r, busy_r, cfg_err_r;
    logic             len_ok_s, arm_s, accept_s, full_s, match_s;

    // Length legality, accepted-bit qualification and the masked compare against the latched pattern.
    always_comb begin
        len_ok_s    = (pat_len != {LEN_W{1'b0}}) && (pat_len <= LEN_W'(PAT_W));
        arm_s       = start && len_ok_s;
        accept_s    = (state_r == RUN) && in_valid && !start && !stop;
        hist_next_s = {history_r, in};
        for (int i = 0; i < PAT_W; i++) begin
            mask_s[i] = (i < int'(len_r));
        end
        fill_inc_s  = {1'b0, fill_r} + (LEN_W+1)'(1);
        full_s      = (fill_inc_s >= {1'b0, len_r});
        match_s     = accept_s && full_s && (((hist_next_s ^ pattern_r) & mask_s) == {PAT_W{1'b0}});
        if (match_s && !overlap_r) begin
            fill_n = {LEN_W{1'b0}};
        end else if (full_s) begin
            fill_n = len_r;
        end else begin
            fill_n = fill_inc_s[LEN_W-1:0];
        end
    end

    // Next-state logic; start outranks stop, and an illegal start always lands in IDLE.
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (arm_s) begin
                    state_n = RUN;
                end else begin
                    state_n = IDLE;
                end
            end
            RUN: begin
                if (start) begin
                    state_n = len_ok_s ? RUN : IDLE;
                end else if (stop) begin
                    state_n = IDLE;
                end else begin
                    state_n = RUN;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Configuration latch plus history and fill tracking.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pattern_r <= '0;
            len_r     <= '0;
            overlap_r <= 1'b0;
            history_r <= '0;
            fill_r    <= '0;
        end else if (arm_s) begin
            pattern_r <= pattern;
            len_r     <= pat_len;
            overlap_r <= overlap;
            history_r <= '0;
            fill_r    <= '0;
        end else if (accept_s) begin
            history_r <= hist_next_s[PAT_W-2:0];
            fill_r    <= fill_n;
        end else begin
            history_r <= history_r;
            fill_r    <= fill_r;
        end
    end

    // Registered status outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_r     <= 1'b0;
            busy_r    <= 1'b0;
            cfg_err_r <= 1'b0;
        end else begin
            out_r     <= match_s;
            busy_r    <= (state_n == RUN);
            cfg_err_r <= start && !len_ok_s;
        end
    end

    assign out     = out_r;
    assign busy    = busy_r;
    assign cfg_err = cfg_err_r;

`ifdef SEQ_DETECTOR_CNT_EN
    seq_detector_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk  (clk),
        .rstn (rstn),
        .clr  (arm_s),
        .inc  (match_s),
        .cnt  (match_cnt)
    );
`else
    assign match_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed scoreboard bench for seq_detector_param (PAT_W=8, CNT_W=2).
module tb_seq_detector_param;

    localparam int PAT_W = 8;
    localparam int CNT_W = 2;
    localparam int LEN_W = 4;

    logic             clk, rstn, in_valid, in_bit, start, stop, overlap;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] pat_len;
    logic             out_bit, busy, cfg_err;
    logic [CNT_W-1:0] match_cnt;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    bit          m_run;
    bit          m_ovl;
    logic [7:0]  m_pat;
    int          m_len;
    int          m_fresh;
    logic [31:0] m_hist;
    int          m_cnt;

    typedef struct packed {
        logic       o;
        logic       b;
        logic       e;
        logic [1:0] c;
    } exp_t;
    exp_t sb[$];

    seq_detector_param #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in        (in_bit),
        .start     (start),
        .stop      (stop),
        .pattern   (pattern),
        .pat_len   (pat_len),
        .overlap   (overlap),
        .out       (out_bit),
        .busy      (busy),
        .cfg_err   (cfg_err),
        .match_cnt (match_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [1:0] exp_cnt();
`ifdef SEQ_DETECTOR_CNT_EN
        return 2'(m_cnt);
`else
        return 2'd0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; the model predicts the outputs seen after the edge.
    task automatic cyc(input logic v, input logic b, input logic st, input logic sp);
        logic        e_out;
        logic        e_err;
        logic [31:0] mask;
        exp_t        e;
        in_valid = v;
        in_bit   = b;
        start    = st;
        stop     = sp;
        e_out    = 1'b0;
        e_err    = 1'b0;
        if (st) begin
            if (pat_len >= 4'd1 && pat_len <= 4'd8) begin
                m_run   = 1'b1;
                m_pat   = pattern;
                m_len   = int'(pat_len);
                m_ovl   = overlap;
                m_hist  = 32'd0;
                m_fresh = 0;
                m_cnt   = 0;
            end else begin
                e_err = 1'b1;
                m_run = 1'b0;
            end
        end else if (sp) begin
            m_run = 1'b0;
        end else if (m_run && v) begin
            m_hist = {m_hist[30:0], b};
            m_fresh++;
            mask = (32'd1 << m_len) - 32'd1;
            if (m_fresh >= m_len && ((m_hist & mask) == ({24'd0, m_pat} & mask))) begin
                e_out = 1'b1;
                if (m_cnt < 3) m_cnt++;
                if (!m_ovl) m_fresh = 0;
            end
        end
        sb.push_back('{e_out, m_run, e_err, exp_cnt()});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("out", {7'd0, out_bit}, {7'd0, e.o});
        chk("busy", {7'd0, busy}, {7'd0, e.b});
        chk("cfg_err", {7'd0, cfg_err}, {7'd0, e.e});
        chk("match_cnt", {6'd0, match_cnt}, {6'd0, e.c});
        pulses += int'(out_bit);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic arm(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
        pattern = pat;
        pat_len = len;
        overlap = ovl;
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        pattern = 8'hA5;
        pat_len = 4'd0;
        overlap = ~ovl;
        pulses  = 0;
    endtask

    // Feed n bits, most significant first, with gap invalid cycles after each.
    task automatic feed(input logic [15:0] bits, input int n, input int gap);
        for (int i = n - 1; i >= 0; i--) begin
            cyc(1'b1, bits[i], 1'b0, 1'b0);
            for (int g = 0; g < gap; g++) begin
                cyc(1'b0, 1'($urandom_range(1, 0)), 1'b0, 1'b0);
            end
        end
    endtask

    initial begin
        rstn = 1'b0; in_valid = 1'b0; in_bit = 1'b0; start = 1'b0; stop = 1'b0;
        pattern = 8'd0; pat_len = 4'd0; overlap = 1'b0;
        m_run = 1'b0; m_ovl = 1'b0; m_pat = 8'd0; m_len = 0; m_fresh = 0; m_hist = 32'd0; m_cnt = 0;
        #12;
        chk("rst_out", {7'd0, out_bit}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_cfg_err", {7'd0, cfg_err}, 8'd0);
        chk("rst_cnt", {6'd0, match_cnt}, 8'd0);
        rstn = 1'b1;

        arm(8'b0000_1101, 4'd4, 1'b1);
        feed(16'b110_1101, 7, 0);
        chk("pulses_1101_ovl", 8'(pulses), 8'd2);

        arm(8'b0000_1101, 4'd4, 1'b0);
        feed(16'b110_1101, 7, 0);
        chk("pulses_1101_novl", 8'(pulses), 8'd1);

        arm(8'b0000_0111, 4'd3, 1'b1);
        feed(16'b1_1111, 5, 0);
        chk("pulses_111_ovl", 8'(pulses), 8'd3);

        arm(8'b0000_0111, 4'd3, 1'b0);
        feed(16'b1_1111, 5, 0);
        chk("pulses_111_novl", 8'(pulses), 8'd1);

        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        pulses  = 0;
        pat_len = 4'd0;
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        pat_len = 4'd9;
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        feed(16'b1111, 4, 0);
        chk("pulses_bad_len", 8'(pulses), 8'd0);

        arm(8'b0000_1101, 4'd4, 1'b1);
        feed(16'b110_1101, 7, 2);
        chk("pulses_gaps", 8'(pulses), 8'd2);

        pattern = 8'b0000_0011; pat_len = 4'd2; overlap = 1'b1;
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        pulses = 0;
        feed(16'b111_1111_1111, 11, 0);
        chk("pulses_sat", 8'(pulses), 8'd10);
`ifdef SEQ_DETECTOR_CNT_EN
        chk("cnt_saturated", {6'd0, match_cnt}, 8'd3);
`else
        chk("cnt_tied", {6'd0, match_cnt}, 8'd0);
`endif

        pat_len = 4'd0;
        cyc(1'b1, 1'b1, 1'b1, 1'b0);

        arm(8'b0000_0011, 4'd2, 1'b1);
        feed(16'b111, 3, 0);
        #3;
        rstn = 1'b0;
        #1;
        m_run = 1'b0; m_cnt = 0; m_fresh = 0; m_hist = 32'd0;
        chk("midrst_out", {7'd0, out_bit}, 8'd0);
        chk("midrst_busy", {7'd0, busy}, 8'd0);
        chk("midrst_cnt", {6'd0, match_cnt}, 8'd0);
        #3;
        rstn = 1'b1;
        pulses = 0;
        feed(16'b1111, 4, 0);
        chk("pulses_after_rst", 8'(pulses), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
